// File: rtl/operand_fetch_pkg.sv
// Shared sizing defaults and register-file slice helper for the operand fetch stage.
package operand_fetch_pkg;
   localparam int DEFAULT_DW    = 16;
   localparam int DEFAULT_AW    = 4;
   localparam int DEFAULT_NREGS = 2 ** DEFAULT_AW;
   localparam int DEFAULT_OPW   = 4;

   // Bit offset of register idx inside the flattened register-file bus.
   function automatic int rf_offset(input int idx, input int dw);
      return idx * dw;
   endfunction
endpackage

// File: rtl/operand_fetch_if.sv
// Decoded-instruction input handshake and operand-bundle output handshake.
interface operand_fetch_if
   import operand_fetch_pkg::*;
#(
   parameter int DW  = DEFAULT_DW,
   parameter int AW  = DEFAULT_AW,
   parameter int OPW = DEFAULT_OPW
);
   logic           in_valid;
   logic           in_ready;
   logic [OPW-1:0] in_op;
   logic [AW-1:0]  in_src_a;
   logic [AW-1:0]  in_src_b;
   logic [AW-1:0]  in_dst;
   logic           in_wr_dst;
   logic           in_use_imm;
   logic [DW-1:0]  in_imm;

   logic           out_valid;
   logic           out_ready;
   logic [OPW-1:0] out_op;
   logic [AW-1:0]  out_dst;
   logic           out_wr_dst;
   logic [DW-1:0]  out_a;
   logic [DW-1:0]  out_b;

   modport master (
      output in_valid, in_op, in_src_a, in_src_b, in_dst, in_wr_dst, in_use_imm, in_imm,
      output out_ready,
      input  in_ready,
      input  out_valid, out_op, out_dst, out_wr_dst, out_a, out_b
   );

   modport slave (
      input  in_valid, in_op, in_src_a, in_src_b, in_dst, in_wr_dst, in_use_imm, in_imm,
      input  out_ready,
      output in_ready,
      output out_valid, out_op, out_dst, out_wr_dst, out_a, out_b
   );
endinterface

// File: rtl/operand_bypass_mux.sv
// Reads one register from the flattened file, bypassing same-cycle writeback data.
module operand_bypass_mux
   import operand_fetch_pkg::*;
#(
   parameter int DW = DEFAULT_DW,
   parameter int AW = DEFAULT_AW
) (
   input  logic [(2**AW)*DW-1:0] i_rf_flat,
   input  logic                  i_wb_write,
   input  logic [AW-1:0]         i_wb_select,
   input  logic [DW-1:0]         i_wb_data,
   input  logic [AW-1:0]         i_sel,
   output logic [DW-1:0]         o_data,
   output logic                  o_wb_hit
);
   localparam int NREGS = 2 ** AW;

   logic [DW-1:0] w_regs [NREGS];

   for (genvar gi = 0; gi < NREGS; gi++) begin : g_unpack
      assign w_regs[gi] = i_rf_flat[rf_offset(gi, DW) +: DW];
   end

   always_comb begin
      o_wb_hit = i_wb_write && (i_wb_select == i_sel);
      o_data   = o_wb_hit ? i_wb_data : w_regs[i_sel];
   end
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: bypassed register reads, RAW scoreboard stall, registered bundle.
module operand_fetch
   import operand_fetch_pkg::*;
#(
   parameter int DW  = DEFAULT_DW,
   parameter int AW  = DEFAULT_AW,
   parameter int OPW = DEFAULT_OPW
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [(2**AW)*DW-1:0] rf_flat,
   input  logic                  wb_write,
   input  logic [AW-1:0]         wb_select,
   input  logic [DW-1:0]         wb_data,
   operand_fetch_if.slave        bus,
   output logic [15:0]           stall_cycles
);
   localparam int NREGS = 2 ** AW;

   logic [DW-1:0]    w_a_raw;
   logic [DW-1:0]    w_b_raw;
   logic [DW-1:0]    w_b_sel;
   logic             w_hit_a;
   logic             w_hit_b;
   logic             w_hz_a;
   logic             w_hz_b;
   logic             w_hazard;
   logic             w_ready;
   logic             w_accept;

   logic [NREGS-1:0] r_pending;
   logic             r_out_valid;
   logic [OPW-1:0]   r_out_op;
   logic [AW-1:0]    r_out_dst;
   logic             r_out_wr_dst;
   logic [DW-1:0]    r_out_a;
   logic [DW-1:0]    r_out_b;
   logic [15:0]      r_stall;

   operand_bypass_mux #(.DW(DW), .AW(AW)) u_mux_a (
      .i_rf_flat   (rf_flat),
      .i_wb_write  (wb_write),
      .i_wb_select (wb_select),
      .i_wb_data   (wb_data),
      .i_sel       (bus.in_src_a),
      .o_data      (w_a_raw),
      .o_wb_hit    (w_hit_a)
   );

   operand_bypass_mux #(.DW(DW), .AW(AW)) u_mux_b (
      .i_rf_flat   (rf_flat),
      .i_wb_write  (wb_write),
      .i_wb_select (wb_select),
      .i_wb_data   (wb_data),
      .i_sel       (bus.in_src_b),
      .o_data      (w_b_raw),
      .o_wb_hit    (w_hit_b)
   );

   // A writeback landing this cycle resolves the hazard because its data is bypassed.
   always_comb begin
      w_hz_a   = r_pending[bus.in_src_a] && !w_hit_a;
      w_hz_b   = !bus.in_use_imm && r_pending[bus.in_src_b] && !w_hit_b;
      w_hazard = w_hz_a || w_hz_b;
      w_ready  = (!r_out_valid || bus.out_ready) && !w_hazard;
      w_accept = bus.in_valid && w_ready;
      w_b_sel  = bus.in_use_imm ? bus.in_imm : w_b_raw;
   end

   // Set beats clear on the same index: the accepted instruction is younger than the writeback.
   for (genvar gi = 0; gi < NREGS; gi++) begin : g_pending
      localparam logic [AW-1:0] IDX = AW'(gi);
      always_ff @(posedge clk) begin
         if (reset) begin
            r_pending[gi] <= 1'b0;
         end else if (w_accept && bus.in_wr_dst && (bus.in_dst == IDX)) begin
            r_pending[gi] <= 1'b1;
         end else if (wb_write && (wb_select == IDX)) begin
            r_pending[gi] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid  <= 1'b0;
         r_out_op     <= '0;
         r_out_dst    <= '0;
         r_out_wr_dst <= 1'b0;
         r_out_a      <= '0;
         r_out_b      <= '0;
      end else if (w_accept) begin
         r_out_valid  <= 1'b1;
         r_out_op     <= bus.in_op;
         r_out_dst    <= bus.in_dst;
         r_out_wr_dst <= bus.in_wr_dst;
         r_out_a      <= w_a_raw;
         r_out_b      <= w_b_sel;
      end else if (bus.out_ready) begin
         r_out_valid  <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall <= '0;
      end else if (bus.in_valid && w_hazard && (r_stall != 16'hFFFF)) begin
         r_stall <= r_stall + 16'd1;
      end
   end

   assign bus.in_ready   = w_ready;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_op     = r_out_op;
   assign bus.out_dst    = r_out_dst;
   assign bus.out_wr_dst = r_out_wr_dst;
   assign bus.out_a      = r_out_a;
   assign bus.out_b      = r_out_b;
   assign stall_cycles   = r_stall;
endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: vector table, hand-built hazard sequences, random run vs model.
module tb_operand_fetch;
   logic           clk = 1'b0;
   logic           reset;
   logic [255:0]   rf_flat;
   logic           wb_write;
   logic [3:0]     wb_select;
   logic [15:0]    wb_data;
   logic [15:0]    stall_cycles;

   operand_fetch_if bus ();

   operand_fetch dut (
      .clk          (clk),
      .reset        (reset),
      .rf_flat      (rf_flat),
      .wb_write     (wb_write),
      .wb_select    (wb_select),
      .wb_data      (wb_data),
      .bus          (bus),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   // Register file as seen by the stage; writebacks land here on the clock edge.
   logic [15:0] rf_m [16];

   always_comb begin
      rf_flat = '0;
      for (int i = 0; i < 16; i++) rf_flat[i*16 +: 16] = rf_m[i];
   end

   int compares   = 0;
   int mismatches = 0;

   // Reference model: set of outstanding destinations plus the expected bundle.
   bit          m_pend [int];
   logic        m_valid;
   logic [3:0]  m_op;
   logic [3:0]  m_dst;
   logic        m_wr;
   logic [15:0] m_a;
   logic [15:0] m_b;
   int          m_stall;

   typedef struct {
      logic [3:0]  a;
      logic [3:0]  b;
      logic        imm_en;
      logic [15:0] imm;
      logic        wbw;
      logic [3:0]  wbs;
      logic [15:0] wbd;
      logic [15:0] ea;
      logic [15:0] eb;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compares++;
      if (act !== exp) begin
         mismatches++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pend.delete();
      m_valid = 1'b0;
      m_op    = '0;
      m_dst   = '0;
      m_wr    = 1'b0;
      m_a     = '0;
      m_b     = '0;
      m_stall = 0;
   endtask

   task automatic set_idle();
      bus.in_valid   = 1'b0;
      bus.in_op      = '0;
      bus.in_src_a   = '0;
      bus.in_src_b   = '0;
      bus.in_dst     = '0;
      bus.in_wr_dst  = 1'b0;
      bus.in_use_imm = 1'b0;
      bus.in_imm     = '0;
      bus.out_ready  = 1'b1;
      wb_write       = 1'b0;
      wb_select      = '0;
      wb_data        = '0;
   endtask

   task automatic issue(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] dst, input logic wr, input logic imm_en,
                        input logic [15:0] imm);
      bus.in_valid   = 1'b1;
      bus.in_op      = op;
      bus.in_src_a   = a;
      bus.in_src_b   = b;
      bus.in_dst     = dst;
      bus.in_wr_dst  = wr;
      bus.in_use_imm = imm_en;
      bus.in_imm     = imm;
   endtask

   task automatic set_wb(input logic w, input logic [3:0] sel, input logic [15:0] data);
      wb_write  = w;
      wb_select = sel;
      wb_data   = data;
   endtask

   // One clock: check in_ready against the model, advance both, check registered outputs.
   task automatic cycle();
      logic        hit_a, hit_b, hz, rdy, acc;
      logic [15:0] va, vb;
      #1;
      hit_a = wb_write && (wb_select == bus.in_src_a);
      hit_b = wb_write && (wb_select == bus.in_src_b);
      va    = hit_a ? wb_data : rf_m[bus.in_src_a];
      vb    = bus.in_use_imm ? bus.in_imm : (hit_b ? wb_data : rf_m[bus.in_src_b]);
      hz    = (m_pend.exists(int'(bus.in_src_a)) && !hit_a) ||
              (!bus.in_use_imm && m_pend.exists(int'(bus.in_src_b)) && !hit_b);
      rdy   = (!m_valid || bus.out_ready) && !hz;
      chk("in_ready", 32'(bus.in_ready), 32'(rdy));
      acc   = bus.in_valid && rdy;
      @(posedge clk);
      if (reset) begin
         model_reset();
      end else begin
         if (bus.in_valid && hz && m_stall < 65535) m_stall++;
         if (acc) begin
            m_valid = 1'b1;
            m_op    = bus.in_op;
            m_dst   = bus.in_dst;
            m_wr    = bus.in_wr_dst;
            m_a     = va;
            m_b     = vb;
            $display("txn t=%0t op=%h dst=%h wr=%b a=%h b=%h", $time, m_op, m_dst, m_wr, m_a, m_b);
         end else if (bus.out_ready) begin
            m_valid = 1'b0;
         end
         if (wb_write) m_pend.delete(int'(wb_select));
         if (acc && bus.in_wr_dst) m_pend[int'(bus.in_dst)] = 1'b1;
      end
      if (wb_write) rf_m[wb_select] = wb_data;
      #1;
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
      if (m_valid) begin
         chk("out_op", 32'(bus.out_op), 32'(m_op));
         chk("out_dst", 32'(bus.out_dst), 32'(m_dst));
         chk("out_wr_dst", 32'(bus.out_wr_dst), 32'(m_wr));
         chk("out_a", 32'(bus.out_a), 32'(m_a));
         chk("out_b", 32'(bus.out_b), 32'(m_b));
      end
   endtask

   initial begin
      logic [15:0] s0;

      vecs[0] = '{4'd3, 4'd5, 1'b0, 16'h0000, 1'b0, 4'd0, 16'h0000, 16'h1234, 16'h00FF};
      vecs[1] = '{4'd5, 4'd3, 1'b1, 16'h8000, 1'b0, 4'd0, 16'h0000, 16'h00FF, 16'h8000};
      vecs[2] = '{4'd0, 4'd15, 1'b0, 16'h0000, 1'b0, 4'd0, 16'h0000, 16'h1100, 16'h110F};
      vecs[3] = '{4'd6, 4'd6, 1'b0, 16'h0000, 1'b1, 4'd6, 16'hCAFE, 16'hCAFE, 16'hCAFE};
      vecs[4] = '{4'd6, 4'd7, 1'b0, 16'h0000, 1'b1, 4'd7, 16'h0001, 16'hCAFE, 16'h0001};
      vecs[5] = '{4'd7, 4'd9, 1'b1, 16'hFFFF, 1'b1, 4'd7, 16'h5555, 16'h5555, 16'hFFFF};
      vecs[6] = '{4'd9, 4'd7, 1'b0, 16'h0000, 1'b1, 4'd4, 16'hAAAA, 16'h1109, 16'h5555};
      vecs[7] = '{4'd4, 4'd4, 1'b0, 16'h0000, 1'b0, 4'd0, 16'h0000, 16'hAAAA, 16'hAAAA};

      for (int i = 0; i < 16; i++) rf_m[i] = 16'h1100 + 16'(i);
      rf_m[3] = 16'h1234;
      rf_m[5] = 16'h00FF;

      set_idle();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_a", 32'(bus.out_a), 32'd0);
      chk("rst_out_b", 32'(bus.out_b), 32'd0);
      chk("rst_stall", 32'(stall_cycles), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Back-to-back independent vectors at full throughput.
      for (int i = 0; i < 8; i++) begin
         issue(4'(i), vecs[i].a, vecs[i].b, 4'(15 - i), 1'b0, vecs[i].imm_en, vecs[i].imm);
         set_wb(vecs[i].wbw, vecs[i].wbs, vecs[i].wbd);
         cycle();
         chk("vec_valid", 32'(bus.out_valid), 32'd1);
         chk("vec_a", 32'(bus.out_a), 32'(vecs[i].ea));
         chk("vec_b", 32'(bus.out_b), 32'(vecs[i].eb));
         chk("vec_op", 32'(bus.out_op), 32'(i));
      end
      set_idle();

      // RAW stall on r2, then resolved by a same-cycle writeback.
      issue(4'h1, 4'd0, 4'd0, 4'd2, 1'b1, 1'b0, 16'h0);
      cycle();
      issue(4'h2, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0);
      s0 = stall_cycles;
      repeat (3) cycle();
      chk("raw_stall_count", 32'(stall_cycles), 32'(s0) + 32'd3);
      chk("raw_stall_ready", 32'(bus.in_ready), 32'd0);
      set_wb(1'b1, 4'd2, 16'hBEEF);
      cycle();
      set_idle();
      chk("raw_fwd_valid", 32'(bus.out_valid), 32'd1);
      chk("raw_fwd_a", 32'(bus.out_a), 32'hBEEF);

      // Immediate B ignores the pending source register.
      issue(4'h3, 4'd0, 4'd1, 4'd2, 1'b1, 1'b0, 16'h0);
      cycle();
      issue(4'h4, 4'd1, 4'd2, 4'd0, 1'b0, 1'b1, 16'h8000);
      cycle();
      chk("imm_valid", 32'(bus.out_valid), 32'd1);
      chk("imm_b", 32'(bus.out_b), 32'h8000);
      set_idle();
      set_wb(1'b1, 4'd2, 16'h2222);
      cycle();
      set_idle();

      // Backpressure: bundle holds for three cycles, then the waiting instruction loads.
      issue(4'hA, 4'd3, 4'd5, 4'd1, 1'b0, 1'b0, 16'h0);
      cycle();
      bus.out_ready = 1'b0;
      issue(4'hB, 4'd5, 4'd3, 4'd1, 1'b0, 1'b0, 16'h0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("hold_a", 32'(bus.out_a), 32'h1234);
         chk("hold_op", 32'(bus.out_op), 32'hA);
         chk("hold_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      cycle();
      chk("release_op", 32'(bus.out_op), 32'hB);
      chk("release_a", 32'(bus.out_a), 32'h00FF);
      chk("release_b", 32'(bus.out_b), 32'h1234);
      set_idle();

      // Set and clear of r7 in the same cycle: set wins.
      issue(4'h5, 4'd0, 4'd0, 4'd7, 1'b1, 1'b0, 16'h0);
      set_wb(1'b1, 4'd7, 16'h7777);
      cycle();
      set_idle();
      issue(4'h6, 4'd7, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0);
      cycle();
      chk("setwins_ready", 32'(bus.in_ready), 32'd0);
      set_idle();
      set_wb(1'b1, 4'd7, 16'h7070);
      cycle();
      set_idle();

      // Reset with a held bundle and r4 pending.
      issue(4'h7, 4'd0, 4'd0, 4'd4, 1'b1, 1'b0, 16'h0);
      cycle();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      chk("rst2_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst2_out_op", 32'(bus.out_op), 32'd0);
      chk("rst2_out_dst", 32'(bus.out_dst), 32'd0);
      chk("rst2_out_wr", 32'(bus.out_wr_dst), 32'd0);
      chk("rst2_out_a", 32'(bus.out_a), 32'd0);
      chk("rst2_out_b", 32'(bus.out_b), 32'd0);
      chk("rst2_stall", 32'(stall_cycles), 32'd0);
      issue(4'h8, 4'd4, 4'd0, 4'd0, 1'b0, 1'b0, 16'h0);
      bus.out_ready = 1'b1;
      #1;
      chk("rst2_no_stall", 32'(bus.in_ready), 32'd1);
      cycle();
      set_idle();

      // Random traffic against the model.
      for (int n = 0; n < 500; n++) begin
         issue(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
               ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), 16'($urandom));
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         set_wb(($urandom_range(0, 1) == 1), 4'($urandom), 16'($urandom));
         reset = ($urandom_range(0, 99) == 0);
         cycle();
      end
      reset = 1'b0;
      set_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
      $finish;
   end
endmodule
